// File: rtl/xfire_fpu_bkm_issuer_pkg.sv
// Shared definitions for the BKM issuer: operand field sizes, op codes and issuer state encodings.
package xfire_fpu_bkm_issuer_pkg;

  localparam int OPSIZE = 4;
  localparam int FSIZE  = 5;

  localparam logic [OPSIZE-1:0] OP_MUL = 4'd0;
  localparam logic [OPSIZE-1:0] OP_EXP = 4'd1;
  localparam logic [OPSIZE-1:0] OP_LOG = 4'd2;
  localparam logic [OPSIZE-1:0] OP_DIV = 4'd3;

  typedef enum logic [1:0] {
    BKMI_IDLE  = 2'd0,
    BKMI_ISSUE = 2'd1,
    BKMI_WAIT  = 2'd2,
    BKMI_RESP  = 2'd3
  } bkmi_state_t;

endpackage

// File: rtl/xfire_fpu_bkm_issuer_if.sv
// Host-side request/response channels of the BKM issuer; the host is master, the issuer is slave.
interface xfire_fpu_bkm_issuer_if #(
  parameter int W = 64
);
  import xfire_fpu_bkm_issuer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_format;
  logic [OPSIZE-1:0] req_op;
  logic [W-1:0]      req_x1;
  logic [W-1:0]      req_y1;
  logic [W-1:0]      req_x2;
  logic [W-1:0]      req_y2;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_x3;
  logic [W-1:0]      rsp_y3;
  logic [FSIZE-1:0]  rsp_flags;
  logic              rsp_timeout;

  modport master (
    output req_valid, req_format, req_op, req_x1, req_y1, req_x2, req_y2,
    input  req_ready,
    input  rsp_valid, rsp_x3, rsp_y3, rsp_flags, rsp_timeout,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_format, req_op, req_x1, req_y1, req_x2, req_y2,
    output req_ready,
    output rsp_valid, rsp_x3, rsp_y3, rsp_flags, rsp_timeout,
    input  rsp_ready
  );

endinterface

// File: rtl/xfire_fpu_bkm_issuer_wdog.sv
// Watchdog for the BKM done wait: cleared on issue, counts while waiting, saturates at TMO-1.
module xfire_fpu_bkm_issuer_wdog #(
  parameter int TMO     = 255,
  parameter int LOG2TMO = 8
) (
  input  logic clk,
  input  logic arst,
  input  logic srst,
  input  logic enable,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [LOG2TMO-1:0] LAST = LOG2TMO'(TMO - 1);

  logic [LOG2TMO-1:0] cnt_q;
  logic [LOG2TMO-1:0] cnt_d;

  // Next count: clear wins, otherwise step until the expiry value is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + LOG2TMO'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (srst) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/xfire_fpu_bkm_issuer.sv
// Initiator for the BKM datapath: takes a request, pulses start, waits for done (or the watchdog)
// and hands the captured result back over the response channel.
module xfire_fpu_bkm_issuer
  import xfire_fpu_bkm_issuer_pkg::*;
#(
  parameter int W       = 64,
  parameter int LOG2W   = 6,
  parameter int TMO     = 255,
  parameter int LOG2TMO = 8
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                srst,
  input  logic                enable,
  xfire_fpu_bkm_issuer_if.slave host,
  output logic                bkm_start,
  output logic [1:0]          bkm_format,
  output logic [OPSIZE-1:0]   bkm_op,
  output logic [W-1:0]        bkm_x1,
  output logic [W-1:0]        bkm_y1,
  output logic [W-1:0]        bkm_x2,
  output logic [W-1:0]        bkm_y2,
  input  logic [W-1:0]        bkm_x3,
  input  logic [W-1:0]        bkm_y3,
  input  logic [FSIZE-1:0]    bkm_flags,
  input  logic                bkm_done,
  output logic                busy
);

  if (((1 << LOG2W) != W) || (TMO < 1) || (TMO > ((1 << LOG2TMO) - 1))) begin : g_param_check
    $error("xfire_fpu_bkm_issuer: inconsistent W/LOG2W or TMO outside 1..2^LOG2TMO-1");
  end

  bkmi_state_t       state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [1:0]        fmt_q, fmt_d;
  logic [OPSIZE-1:0] op_q, op_d;
  logic [W-1:0]      x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [W-1:0]      rsp_x3_q, rsp_x3_d, rsp_y3_q, rsp_y3_d;
  logic [FSIZE-1:0]  rsp_flags_q, rsp_flags_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              wdog_expired;

  xfire_fpu_bkm_issuer_wdog #(.TMO(TMO), .LOG2TMO(LOG2TMO)) u_wdog (
    .clk     (clk),
    .arst    (arst),
    .srst    (srst),
    .enable  (enable),
    .clr     (state_q == BKMI_ISSUE),
    .cnt_en  (state_q == BKMI_WAIT),
    .expired (wdog_expired)
  );

  // Next-state and next-output logic; done has priority over the watchdog in WAIT.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    busy_d        = busy_q;
    start_d       = start_q;
    fmt_d         = fmt_q;
    op_d          = op_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    x2_d          = x2_q;
    y2_d          = y2_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_x3_d      = rsp_x3_q;
    rsp_y3_d      = rsp_y3_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      BKMI_IDLE: begin
        if (host.req_valid && req_ready_q) begin
          fmt_d       = host.req_format;
          op_d        = host.req_op;
          x1_d        = host.req_x1;
          y1_d        = host.req_y1;
          x2_d        = host.req_x2;
          y2_d        = host.req_y2;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          start_d     = 1'b1;
          state_d     = BKMI_ISSUE;
        end else begin
          state_d = BKMI_IDLE;
        end
      end
      BKMI_ISSUE: begin
        start_d = 1'b0;
        state_d = BKMI_WAIT;
      end
      BKMI_WAIT: begin
        if (bkm_done) begin
          rsp_x3_d      = bkm_x3;
          rsp_y3_d      = bkm_y3;
          rsp_flags_d   = bkm_flags;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = BKMI_RESP;
        end else if (wdog_expired) begin
          rsp_x3_d      = '0;
          rsp_y3_d      = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = BKMI_RESP;
        end else begin
          state_d = BKMI_WAIT;
        end
      end
      BKMI_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = BKMI_IDLE;
        end else begin
          state_d = BKMI_RESP;
        end
      end
      default: begin
        state_d     = BKMI_IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        start_d     = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; srst outranks enable, enable low freezes everything.
  always_ff @(posedge clk or posedge arst) begin
    if (arst || srst) begin
      state_q       <= BKMI_IDLE;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      fmt_q         <= 2'd0;
      op_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      x2_q          <= '0;
      y2_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_x3_q      <= '0;
      rsp_y3_q      <= '0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (enable) begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      start_q       <= start_d;
      fmt_q         <= fmt_d;
      op_q          <= op_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      x2_q          <= x2_d;
      y2_q          <= y2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_x3_q      <= rsp_x3_d;
      rsp_y3_q      <= rsp_y3_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign host.req_ready   = req_ready_q;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_x3      = rsp_x3_q;
  assign host.rsp_y3      = rsp_y3_q;
  assign host.rsp_flags   = rsp_flags_q;
  assign host.rsp_timeout = rsp_timeout_q;
  assign bkm_start        = start_q;
  assign bkm_format       = fmt_q;
  assign bkm_op           = op_q;
  assign bkm_x1           = x1_q;
  assign bkm_y1           = y1_q;
  assign bkm_x2           = x2_q;
  assign bkm_y2           = y2_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_xfire_fpu_bkm_issuer.sv
// Bench for xfire_fpu_bkm_issuer: transaction-age reference model, per-cycle compare, directed scenarios.
module tb_xfire_fpu_bkm_issuer;
  import xfire_fpu_bkm_issuer_pkg::*;

  localparam int W = 64;
  localparam int LOG2W = 6;
  localparam int TMO = 16;
  localparam int LOG2TMO = 8;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic srst = 1'b0;
  logic enable = 1'b1;
  logic bkm_start, busy;
  logic [1:0] bkm_format;
  logic [OPSIZE-1:0] bkm_op;
  logic [W-1:0] bkm_x1, bkm_y1, bkm_x2, bkm_y2;
  logic [W-1:0] bkm_x3 = '0;
  logic [W-1:0] bkm_y3 = '0;
  logic [FSIZE-1:0] bkm_flags = '0;
  logic bkm_done = 1'b0;

  xfire_fpu_bkm_issuer_if #(.W(W)) host ();

  xfire_fpu_bkm_issuer #(.W(W), .LOG2W(LOG2W), .TMO(TMO), .LOG2TMO(LOG2TMO)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .host(host),
    .bkm_start(bkm_start), .bkm_format(bkm_format), .bkm_op(bkm_op),
    .bkm_x1(bkm_x1), .bkm_y1(bkm_y1), .bkm_x2(bkm_x2), .bkm_y2(bkm_y2),
    .bkm_x3(bkm_x3), .bkm_y3(bkm_y3), .bkm_flags(bkm_flags), .bkm_done(bkm_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int n_start = 0;
  bit done_en = 1'b0;
  int done_dly = 0;

  // Reference model: m_a is the enabled-cycle age of the open transaction (1 = start cycle).
  bit m_active = 1'b0;
  bit m_resp = 1'b0;
  int m_a = 0;
  int m_acc = 0;
  logic [1:0] m_fmt = '0;
  logic [OPSIZE-1:0] m_op = '0;
  logic [W-1:0] m_x1 = '0, m_y1 = '0, m_x2 = '0, m_y2 = '0, m_x3 = '0, m_y3 = '0;
  logic [FSIZE-1:0] m_flags = '0;
  bit m_to = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge arst) begin
    if (arst || srst) begin
      m_active <= 1'b0;
      m_resp <= 1'b0;
      m_a <= 0;
    end else if (enable) begin
      if (!m_active) begin
        if (host.req_valid) begin
          m_active <= 1'b1;
          m_resp <= 1'b0;
          m_a <= 1;
          m_acc <= m_acc + 1;
          m_fmt <= host.req_format;
          m_op <= host.req_op;
          m_x1 <= host.req_x1;
          m_y1 <= host.req_y1;
          m_x2 <= host.req_x2;
          m_y2 <= host.req_y2;
        end
      end else if (!m_resp) begin
        if (m_a >= 2 && bkm_done) begin
          m_resp <= 1'b1;
          m_x3 <= bkm_x3;
          m_y3 <= bkm_y3;
          m_flags <= bkm_flags;
          m_to <= 1'b0;
        end else if (m_a == TMO + 1) begin
          m_resp <= 1'b1;
          m_x3 <= '0;
          m_y3 <= '0;
          m_flags <= '0;
          m_to <= 1'b1;
        end
        m_a <= m_a + 1;
      end else if (host.rsp_ready) begin
        m_active <= 1'b0;
      end
    end
  end

  // BKM stand-in: done is raised done_dly cycles after the start cycle.
  always @(posedge clk) begin
    #1;
    bkm_done <= done_en && m_active && !m_resp && (m_a == 1 + done_dly);
  end

  always @(posedge clk) begin
    if (enable && bkm_start && !arst && !srst) n_start <= n_start + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(host.req_ready), 64'(!m_active));
      chk("busy", 64'(busy), 64'(m_active));
      chk("bkm_start", 64'(bkm_start), 64'(m_active && !m_resp && (m_a == 1)));
      chk("rsp_valid", 64'(host.rsp_valid), 64'(m_active && m_resp));
      if (m_active && m_resp) begin
        chk("rsp_x3", host.rsp_x3, m_x3);
        chk("rsp_y3", host.rsp_y3, m_y3);
        chk("rsp_flags", 64'(host.rsp_flags), 64'(m_flags));
        chk("rsp_timeout", 64'(host.rsp_timeout), 64'(m_to));
      end
      if (m_active && !m_resp) begin
        chk("bkm_fmt_op", 64'({bkm_format, bkm_op}), 64'({m_fmt, m_op}));
        chk("bkm_x1", bkm_x1, m_x1);
        chk("bkm_y1", bkm_y1, m_y1);
        chk("bkm_x2", bkm_x2, m_x2);
        chk("bkm_y2", bkm_y2, m_y2);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input logic [OPSIZE-1:0] op, input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input logic [W-1:0] x2, input logic [W-1:0] y2, input logic [1:0] fmt);
    int c0;
    bit ok;
    c0 = m_acc;
    ok = 1'b0;
    host.req_op = op;
    host.req_x1 = x1;
    host.req_y1 = y1;
    host.req_x2 = x2;
    host.req_y2 = y2;
    host.req_format = fmt;
    host.req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (m_acc != c0) begin
        ok = 1'b1;
        break;
      end
    end
    host.req_valid = 1'b0;
    chk("req_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!host.rsp_valid && lat < 200) begin
      tick(1);
      lat++;
    end
    chk("rsp_arrived", 64'(host.rsp_valid), 64'd1);
  endtask

  task automatic do_rsp();
    host.rsp_ready = 1'b1;
    tick(1);
    host.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int s0;
    int c0;
    host.req_valid = 1'b0;
    host.req_format = 2'd0;
    host.req_op = '0;
    host.req_x1 = '0;
    host.req_y1 = '0;
    host.req_x2 = '0;
    host.req_y2 = '0;
    host.rsp_ready = 1'b0;

    // Reset state.
    #2 arst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(host.req_ready), 64'd1);
    chk("rst_outputs", 64'({busy, bkm_start, host.rsp_valid, host.rsp_timeout}), 64'd0);
    chk("rst_bkm_x1", bkm_x1, 64'd0);
    @(posedge clk);
    #1 arst = 1'b0;
    chk_en = 1'b1;

    // Normal transaction.
    bkm_x3 = 64'hAAAA;
    bkm_y3 = 64'h5555;
    bkm_flags = 5'h02;
    done_en = 1'b1;
    done_dly = 10;
    s0 = n_start;
    do_req(OP_EXP, 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
           64'h0000_0000_0000_0002, 2'd1);
    chk("norm_bkm_x1", bkm_x1, 64'h3FF0_0000_0000_0000);
    chk("norm_bkm_op", 64'(bkm_op), 64'd1);
    wait_rsp(lat);
    chk("norm_latency", 64'(lat), 64'd12);
    chk("norm_rsp_x3", host.rsp_x3, 64'hAAAA);
    chk("norm_rsp_y3", host.rsp_y3, 64'h5555);
    chk("norm_rsp_flags", 64'(host.rsp_flags), 64'h2);
    chk("norm_rsp_timeout", 64'(host.rsp_timeout), 64'd0);
    chk("norm_start_pulses", 64'(n_start - s0), 64'd1);
    do_rsp();

    // Watchdog timeout.
    done_en = 1'b0;
    do_req(OP_LOG, 64'h1234, 64'h5678, 64'h9ABC, 64'hDEF0, 2'd2);
    wait_rsp(lat);
    chk("tmo_latency", 64'(lat), 64'd18);
    chk("tmo_rsp_timeout", 64'(host.rsp_timeout), 64'd1);
    chk("tmo_rsp_data", host.rsp_x3 | host.rsp_y3 | 64'(host.rsp_flags), 64'd0);
    do_rsp();
    chk("tmo_busy_after", 64'(busy), 64'd0);

    // Done in the expiry cycle.
    bkm_x3 = 64'h1234_5678;
    bkm_y3 = 64'h8765_4321;
    bkm_flags = 5'h1F;
    done_en = 1'b1;
    done_dly = TMO;
    do_req(OP_DIV, 64'h1, 64'h2, 64'h3, 64'h4, 2'd3);
    wait_rsp(lat);
    chk("coll_latency", 64'(lat), 64'd18);
    chk("coll_rsp_timeout", 64'(host.rsp_timeout), 64'd0);
    chk("coll_rsp_x3", host.rsp_x3, 64'h1234_5678);
    chk("coll_rsp_flags", 64'(host.rsp_flags), 64'h1F);
    do_rsp();

    // Response backpressure with a queued second request.
    bkm_x3 = 64'hBEEF;
    bkm_y3 = 64'hCAFE;
    bkm_flags = 5'h11;
    done_dly = 3;
    do_req(OP_MUL, 64'h11, 64'h22, 64'h33, 64'h44, 2'd0);
    wait_rsp(lat);
    chk("bp_latency", 64'(lat), 64'd5);
    host.req_x1 = 64'h0BAD_F00D;
    host.req_op = OP_LOG;
    host.req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bkm_x3 = {$urandom, $urandom};
      bkm_y3 = {$urandom, $urandom};
      tick(1);
    end
    chk("bp_rsp_x3_held", host.rsp_x3, 64'hBEEF);
    chk("bp_req_ready_low", 64'(host.req_ready), 64'd0);
    c0 = m_acc;
    host.rsp_ready = 1'b1;
    tick(1);
    host.rsp_ready = 1'b0;
    chk("bp_req_ready_after", 64'(host.req_ready), 64'd1);
    chk("bp_not_yet_accepted", 64'(busy), 64'd0);
    tick(1);
    host.req_valid = 1'b0;
    chk("bp_second_start", 64'(bkm_start), 64'd1);
    chk("bp_second_x1", bkm_x1, 64'h0BAD_F00D);
    chk("bp_model_accept", 64'(m_acc - c0), 64'd1);
    wait_rsp(lat);
    do_rsp();

    // enable held low during the start cycle.
    done_dly = 5;
    s0 = n_start;
    do_req(OP_EXP, 64'h77, 64'h88, 64'h99, 64'hAA, 2'd1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("en_start_held", 64'(bkm_start), 64'd1);
    end
    enable = 1'b1;
    tick(1);
    chk("en_start_dropped", 64'(bkm_start), 64'd0);
    chk("en_start_pulses", 64'(n_start - s0), 64'd1);
    wait_rsp(lat);
    do_rsp();

    // Asynchronous reset while waiting for done.
    done_en = 1'b0;
    do_req(OP_MUL, 64'h5, 64'h6, 64'h7, 64'h8, 2'd0);
    tick(5);
    #1 arst = 1'b1;
    #1;
    chk("arst_req_ready", 64'(host.req_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    #1 arst = 1'b0;
    tick(4);
    chk("arst_no_rsp", 64'(host.rsp_valid), 64'd0);
    done_en = 1'b1;
    done_dly = 2;
    bkm_x3 = 64'h600D;
    do_req(OP_EXP, 64'h9, 64'hA, 64'hB, 64'hC, 2'd2);
    wait_rsp(lat);
    chk("arst_next_latency", 64'(lat), 64'd4);
    chk("arst_next_x3", host.rsp_x3, 64'h600D);
    do_rsp();

    // Synchronous reset while waiting for done.
    done_en = 1'b0;
    do_req(OP_DIV, 64'hD, 64'hE, 64'hF, 64'h10, 2'd3);
    tick(5);
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
    chk("srst_req_ready", 64'(host.req_ready), 64'd1);
    chk("srst_busy", 64'(busy), 64'd0);
    tick(3);
    done_en = 1'b1;
    done_dly = 4;
    bkm_x3 = 64'hF00D;
    do_req(OP_LOG, 64'h20, 64'h21, 64'h22, 64'h23, 2'd1);
    wait_rsp(lat);
    chk("srst_next_latency", 64'(lat), 64'd6);
    chk("srst_next_x3", host.rsp_x3, 64'hF00D);
    do_rsp();
    tick(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xfire_fpu_bkm_issuer.md
Name: xfire_fpu_bkm_issuer

Overview:
Initiator-side controller that drives the xfire_fpu_bkm datapath. It accepts complex-operand requests over a valid/ready channel and issues a one-cycle start to the BKM unit. It then waits for done, captures x3/y3/flags and returns them on a valid/ready response channel. A watchdog aborts the transaction if the BKM unit never asserts done.

Parameters:
W, 64, operand/result width in bits
LOG2W, 6, log2(W), carried for consistency with the BKM unit
TMO, 255, max cycles waited for bkm_done after start; legal range 1..2^LOG2TMO-1
LOG2TMO, 8, width of the watchdog counter

Ports:
clk  in  1  posedge clock
arst  in  1  asynchronous reset, active-high
srst  in  1  synchronous reset, active-high
enable  in  1  synchronous enable; low freezes all state and outputs
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_format  in  2  operand format, forwarded to BKM
req_op  in  `OPSIZE  operation code
req_x1, req_y1, req_x2, req_y2  in  W each  complex operands
bkm_start  out  1  single-cycle start pulse to BKM unit
bkm_format  out  2  registered format
bkm_op  out  `OPSIZE  registered op
bkm_x1, bkm_y1, bkm_x2, bkm_y2  out  W each  registered operands, stable from start until done
bkm_x3, bkm_y3  in  W each  BKM results
bkm_flags  in  `FSIZE  BKM exception flags
bkm_done  in  1  BKM completion, sampled only in WAIT
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_x3, rsp_y3  out  W each  captured results
rsp_flags  out  `FSIZE  captured flags
rsp_timeout  out  1  response produced by watchdog, not by done
busy  out  1  state != IDLE

Behaviour:
- Reset (arst asynchronous, or srst on a clock edge with priority over enable):
  - State returns to IDLE.
  - All outputs go to 0, except req_ready = 1.
  - Watchdog counter goes to 0.
  - Reset mid-transaction drops the transaction; no response is produced.
- enable = 0: no state, counter or output register changes; a held bkm_start stays asserted.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch format, op and operands into the bkm_* registers, then go to ISSUE.
- ISSUE: bkm_start = 1 for exactly one enabled cycle; clear the counter; go to WAIT.
- WAIT:
  - bkm_start = 0.
  - bkm_done = 1: capture bkm_x3/bkm_y3/bkm_flags into the rsp_* registers, set rsp_timeout = 0, go to RESP.
  - Else, counter == TMO-1: set rsp_x3 = rsp_y3 = 0, rsp_flags = 0, rsp_timeout = 1, go to RESP.
  - Else: counter increments.
  - done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid = 1; response data is held stable while rsp_ready = 0.
  - On rsp_ready: rsp_valid drops next cycle and state goes to IDLE.
  - req_ready = 1 is asserted the cycle after the handshake, so the minimum request-to-request spacing is 4 cycles.
- bkm_done outside WAIT is ignored.
- Latency: request accept to rsp_valid = 2 + d cycles, where d is the BKM done delay counted from the cycle after start.
- Operands are only updated in IDLE on an accepted request.

Decomposition:
- Shared package xfire_fpu_bkm_defs.vh:
  - `OPSIZE, `FSIZE and the op codes.
  - New state encodings `BKMI_IDLE, `BKMI_ISSUE, `BKMI_WAIT, `BKMI_RESP (2-bit).
- One sub-module is natural: xfire_fpu_bkm_wdog, the watchdog counter (clear, enable, count, expire at TMO-1).
- The FSM and capture registers stay in the top.

Test Plan:
- Normal transaction: request op=1, x1=0x3FF0..0; BKM model asserts done 10 cycles after start with x3=0xAAAA, y3=0x5555, flags=0x2 -> exactly one bkm_start pulse; rsp_valid 12 cycles after accept; rsp_x3=0xAAAA, rsp_y3=0x5555, rsp_flags=0x2, rsp_timeout=0.
- Timeout: TMO=16 and BKM never asserts done -> rsp_valid with rsp_timeout=1 and all data 0; busy drops after the rsp handshake.
- Backpressure: rsp_ready held low 20 cycles while BKM data changes -> rsp_* stable; a second req_valid meanwhile sees req_ready=0; it is accepted the cycle after rsp_ready.
- Done/timeout collision: done asserted in the exact expiry cycle -> rsp_timeout=0 and the BKM data is captured.
- enable gating: deassert enable during ISSUE for 3 cycles -> bkm_start stays high for those cycles, then is high for exactly one enabled cycle.
- Reset mid-WAIT: arst pulse (not clock-aligned) -> IDLE immediately, req_ready=1, no rsp_valid; a following request completes normally. Repeat with srst.
